// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the datapath and the HI/LO mult/div unit
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] Operand_A;
    logic [WIDTH-1:0] Operand_B;
    logic             Write_Hi;
    logic             Write_Lo;
    logic [WIDTH-1:0] Write_Data;
    logic             Read_Hi_Lo;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
    logic             Stall;

    modport master (
        output Start, Op, Operand_A, Operand_B, Write_Hi, Write_Lo, Write_Data, Read_Hi_Lo,
        input  Hi, Lo, Busy, Done, Stall
    );

    modport slave (
        input  Start, Op, Operand_A, Operand_B, Write_Hi, Write_Lo, Write_Data, Read_Hi_Lo,
        output Hi, Lo, Busy, Done, Stall
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 MULT/MULTU/DIV/DIVU unit holding the HI/LO registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           Clock,
    input logic           Reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_next;

    logic [CW-1:0]    counter;
    logic [1:0]       op_q;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_raw, wa, wb, mq;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;
    logic             busy;

    logic             is_div, is_signed, flip;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign flip      = is_signed & (sign_a ^ sign_b);

    assign a_neg = ~bus.Op[0] & bus.Operand_A[WIDTH-1];
    assign b_neg = ~bus.Op[0] & bus.Operand_B[WIDTH-1];
    assign mag_a = a_neg ? (~bus.Operand_A + 1'b1) : bus.Operand_A;
    assign mag_b = b_neg ? (~bus.Operand_B + 1'b1) : bus.Operand_B;

    // Multiply keeps the multiplier in mq; divide keeps the dividend there and shifts quotient bits in.
    assign mul_sum   = {1'b0, acc[WIDTH-1:0]} + (mq[0] ? {1'b0, wa} : '0);
    assign div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, wb};

    assign prod     = {acc[WIDTH-1:0], mq};
    assign prod_fix = flip ? (~prod + 1'b1) : prod;

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (wb == '0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_lo = flip ? (~mq + 1'b1) : mq;
                res_hi = (is_signed & sign_a) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.Start) state_next = RUN;
            RUN:     if (counter == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        bus.Busy  = busy;
        bus.Stall = busy & (bus.Start | bus.Read_Hi_Lo | bus.Write_Hi | bus.Write_Lo);
    end

    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
    assign bus.Done = done_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            counter <= '0;
            op_q    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            a_raw   <= '0;
            wa      <= '0;
            wb      <= '0;
            mq      <= '0;
            acc     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        op_q    <= bus.Op;
                        sign_a  <= bus.Operand_A[WIDTH-1];
                        sign_b  <= bus.Operand_B[WIDTH-1];
                        a_raw   <= bus.Operand_A;
                        wa      <= mag_a;
                        wb      <= mag_b;
                        mq      <= bus.Op[1] ? mag_a : mag_b;
                        acc     <= '0;
                        counter <= '0;
                    end else begin
                        if (bus.Write_Hi) hi_q <= bus.Write_Data;
                        if (bus.Write_Lo) lo_q <= bus.Write_Data;
                    end
                end
                RUN: begin
                    counter <= counter + 1'b1;
                    if (!is_div) begin
                        acc <= {1'b0, mul_sum[WIDTH:1]};
                        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    end else if (div_diff[WIDTH+1]) begin
                        acc <= div_shift;
                        mq  <= {mq[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= div_diff[WIDTH:0];
                        mq  <= {mq[WIDTH-2:0], 1'b1};
                    end
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed and random checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'b0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic with_write);
        logic [63:0] exp;
        logic [31:0] prev_hi, prev_lo;
        int n;
        exp = ref_model(op, a, b);
        prev_hi = bus.Hi;
        prev_lo = bus.Lo;
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = op; bus.Operand_A = a; bus.Operand_B = b;
        bus.Write_Lo = with_write; bus.Write_Data = ~prev_lo;
        @(negedge clk);
        bus.Start = 1'b0; bus.Write_Lo = 1'b0;
        bus.Operand_A = $urandom; bus.Operand_B = $urandom;
        check({tag, "_hold_hi"}, 64'(bus.Hi), 64'(prev_hi));
        check({tag, "_hold_lo"}, 64'(bus.Lo), 64'(prev_lo));
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, 64'(bus.Done), 64'd1);
        check({tag, "_hi"}, 64'(bus.Hi), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(bus.Lo), 64'(exp[31:0]));
        @(negedge clk);
        check({tag, "_done_clear"}, 64'(bus.Done), 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] ra, rb, prev_lo;
        logic [1:0]  rop;
        int n;

        bus.Start = 1'b0; bus.Op = 2'b00; bus.Operand_A = '0; bus.Operand_B = '0;
        bus.Write_Hi = 1'b0; bus.Write_Lo = 1'b0; bus.Write_Data = '0; bus.Read_Hi_Lo = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_hi", 64'(bus.Hi), 64'd0);
        check("rst_lo", 64'(bus.Lo), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_stall", 64'(bus.Stall), 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult_neg_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
        check("mult_min_const", {bus.Hi, bus.Lo}, 64'h4000_0000_0000_0000);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_neg_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_const", {bus.Hi, bus.Lo}, 64'h0000_0000_8000_0000);
        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        check("divu_100_7_const", {bus.Hi, bus.Lo}, 64'h0000_0002_0000_000E);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 1'b0);
        check("divu_zero_const", {bus.Hi, bus.Lo}, 64'h0000_0005_FFFF_FFFF);
        run_op("div_zero", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b1);
        check("div_zero_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFB_FFFF_FFFF);

        // Requests while busy must stall and be ignored.
        exp = ref_model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 2'b01; bus.Operand_A = 32'h1234_5678; bus.Operand_B = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.Start = 1'b0;
        #1 check("run_idle_stall", 64'(bus.Stall), 64'd0);
        @(negedge clk);
        bus.Start = 1'b1; bus.Op = 2'b11; bus.Operand_A = 32'd100; bus.Operand_B = 32'd3;
        #1 check("stall_start", 64'(bus.Stall), 64'd1);
        @(negedge clk);
        bus.Start = 1'b0; bus.Write_Hi = 1'b1; bus.Write_Data = 32'hDEAD_BEEF;
        #1 check("stall_write", 64'(bus.Stall), 64'd1);
        @(negedge clk);
        bus.Write_Hi = 1'b0; bus.Read_Hi_Lo = 1'b1;
        #1 check("stall_read", 64'(bus.Stall), 64'd1);
        @(negedge clk);
        bus.Read_Hi_Lo = 1'b0;
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("stall_busy_cycles", 64'(n), 64'd29);
        check("stall_result", {bus.Hi, bus.Lo}, exp);
        @(negedge clk);
        check("stall_no_second_op", 64'(bus.Busy), 64'd0);

        prev_lo = bus.Lo;
        bus.Write_Hi = 1'b1; bus.Write_Data = 32'h0000_1234; bus.Read_Hi_Lo = 1'b1;
        #1 check("mthi_stall", 64'(bus.Stall), 64'd0);
        @(negedge clk);
        bus.Write_Hi = 1'b0; bus.Read_Hi_Lo = 1'b0;
        check("mthi_hi", 64'(bus.Hi), 64'h1234);
        check("mthi_lo_kept", 64'(bus.Lo), 64'(prev_lo));
        bus.Write_Hi = 1'b1; bus.Write_Lo = 1'b1; bus.Write_Data = 32'hCAFE_F00D;
        @(negedge clk);
        bus.Write_Hi = 1'b0; bus.Write_Lo = 1'b0;
        check("mthilo_both", {bus.Hi, bus.Lo}, 64'hCAFE_F00D_CAFE_F00D);

        // Reset in the middle of an operation.
        bus.Start = 1'b1; bus.Op = 2'b00; bus.Operand_A = 32'h7; bus.Operand_B = 32'h9;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.Read_Hi_Lo = 1'b1;
        #1;
        check("mid_rst_busy", 64'(bus.Busy), 64'd0);
        check("mid_rst_done", 64'(bus.Done), 64'd0);
        check("mid_rst_stall", 64'(bus.Stall), 64'd0);
        check("mid_rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
        bus.Read_Hi_Lo = 1'b0;
        run_op("post_rst_mult", 2'b00, 32'hFFFF_FF00, 32'h0001_0001, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
